config_frame_loader: RTL and testbench

- Upstream feeder of every tile ConfigMem.
- Consumes a 32-bit configuration word stream (from UART/SPI/host bridge) via valid/ready.
- Parses sync/header/data, assembles one full column frame across all rows, then fires a one-cycle frame strobe for one column so the tile latches capture FrameData.
- Sits between the bitstream source and the fabric-wide FrameData/FrameStrobe distribution.

---
 rtl/config_loader_pkg.sv | 21 ++
 rtl/config_onehot_decoder.sv | 23 ++
 rtl/config_frame_loader.sv | 154 +++++++++++++++
 tb/tb_config_frame_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/config_loader_pkg.sv
// Shared state encoding, header layout and opcodes for the configuration frame loader.
// Types and constants only; no timing or handshake of its own.
// Imported by the loader top and its index decoder.
package config_loader_pkg;

  typedef enum logic [2:0] {IDLE, HEADER, DATA, STROBE, HOLD} state_t;

  localparam int WORD_W  = 32;
  localparam int FIELD_W = 8;

  // Header layout: [31:24] opcode, [23:16] column, [15:8] frame, [7:0] reserved.
  localparam int HDR_OP_LSB  = 24;
  localparam int HDR_COL_LSB = 16;
  localparam int HDR_FRM_LSB = 8;

  localparam logic [FIELD_W-1:0] OP_FRAME_WRITE = 8'h01;
  localparam logic [FIELD_W-1:0] OP_DESYNC      = 8'h02;

  localparam logic [WORD_W-1:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

endpackage

// File: rtl/config_onehot_decoder.sv
// Index to one-hot decoder with an in-range flag; out-of-range yields all zeros.
// Purely combinational, zero latency.
// No handshake; the caller qualifies the result.
module config_onehot_decoder
  import config_loader_pkg::*;
#(
  parameter int N  = 16,
  parameter int IW = FIELD_W
) (
  input  logic [IW-1:0] i_idx,
  output logic [N-1:0]  o_onehot,
  output logic          o_valid
);

  always_comb begin
    o_onehot = '0;
    o_valid  = (32'(i_idx) < N);
    for (int k = 0; k < N; k++) begin
      o_onehot[k] = (i_idx == IW'(k));
    end
  end

endmodule

// File: rtl/config_frame_loader.sv
// Parses a sync/header/data word stream and strobes one assembled column frame into the fabric.
// Strobe one cycle after the last data word; next header accepted three cycles after it at earliest.
// s_ready drops for the strobe and hold cycles only; s_valid gaps in DATA stall without timeout.
module config_frame_loader
  import config_loader_pkg::*;
#(
  parameter int                NumberOfRows    = 16,
  parameter int                NumberOfCols    = 16,
  parameter int                FrameBitsPerRow = 32,
  parameter int                MaxFramesPerCol = 20,
  parameter logic [WORD_W-1:0] SYNC_WORD       = SYNC_WORD_DEFAULT
) (
  input  logic                                    CLK,
  input  logic                                    resetn,
  input  logic [WORD_W-1:0]                       s_data,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic [NumberOfCols-1:0]                 ColSelect,
  output logic                                    synced,
  output logic                                    busy,
  output logic                                    error,
  output logic [15:0]                             frame_count
);

  localparam int                RowW     = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam logic [RowW-1:0]   LAST_ROW = RowW'(NumberOfRows - 1);

  state_t                                  r_state;
  logic                                    r_s_ready;
  logic                                    r_synced;
  logic                                    r_busy;
  logic                                    r_error;
  logic [15:0]                             r_frame_count;
  logic [RowW-1:0]                         r_row;
  logic [NumberOfRows*FrameBitsPerRow-1:0] r_frame_data;
  logic [MaxFramesPerCol-1:0]              r_frm_oh;
  logic [NumberOfCols-1:0]                 r_col_oh;
  logic [MaxFramesPerCol-1:0]              r_strobe;
  logic [NumberOfCols-1:0]                 r_colsel;

  logic                       w_acc;
  logic                       w_is_sync;
  logic [FIELD_W-1:0]         w_opcode;
  logic [NumberOfCols-1:0]    w_col_oh;
  logic                       w_col_vld;
  logic [MaxFramesPerCol-1:0] w_frm_oh;
  logic                       w_frm_vld;

  assign w_acc     = s_valid & r_s_ready;
  assign w_is_sync = (s_data == SYNC_WORD);
  assign w_opcode  = s_data[HDR_OP_LSB +: FIELD_W];

  config_onehot_decoder #(.N(NumberOfCols), .IW(FIELD_W)) u_col_dec (
    .i_idx    (s_data[HDR_COL_LSB +: FIELD_W]),
    .o_onehot (w_col_oh),
    .o_valid  (w_col_vld)
  );

  config_onehot_decoder #(.N(MaxFramesPerCol), .IW(FIELD_W)) u_frm_dec (
    .i_idx    (s_data[HDR_FRM_LSB +: FIELD_W]),
    .o_onehot (w_frm_oh),
    .o_valid  (w_frm_vld)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_s_ready     <= 1'b0;
      r_synced      <= 1'b0;
      r_busy        <= 1'b0;
      r_error       <= 1'b0;
      r_frame_count <= '0;
      r_row         <= '0;
      r_frame_data  <= '0;
      r_frm_oh      <= '0;
      r_col_oh      <= '0;
      r_strobe      <= '0;
      r_colsel      <= '0;
    end else begin
      r_strobe <= '0;
      r_colsel <= '0;
      case (r_state)
        IDLE: begin
          r_s_ready <= 1'b1;
          if (w_acc && w_is_sync) begin
            r_state  <= HEADER;
            r_synced <= 1'b1;
            r_error  <= 1'b0;
          end
        end
        HEADER: begin
          // The sync word carries an illegal opcode, so it must be screened first.
          if (w_acc && !w_is_sync) begin
            if (w_opcode == OP_FRAME_WRITE && w_col_vld && w_frm_vld) begin
              r_state  <= DATA;
              r_busy   <= 1'b1;
              r_row    <= '0;
              r_col_oh <= w_col_oh;
              r_frm_oh <= w_frm_oh;
            end else if (w_opcode == OP_DESYNC) begin
              r_state  <= IDLE;
              r_synced <= 1'b0;
            end else begin
              r_state  <= IDLE;
              r_synced <= 1'b0;
              r_error  <= 1'b1;
            end
          end
        end
        DATA: begin
          if (w_acc) begin
            r_frame_data[int'(r_row)*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
            r_row <= r_row + 1'b1;
            if (r_row == LAST_ROW) begin
              r_state   <= STROBE;
              r_s_ready <= 1'b0;
              r_strobe  <= r_frm_oh;
              r_colsel  <= r_col_oh;
              if (r_frame_count != 16'hFFFF) begin
                r_frame_count <= r_frame_count + 16'd1;
              end
            end
          end
        end
        STROBE: begin
          r_state <= HOLD;
        end
        HOLD: begin
          r_state   <= HEADER;
          r_s_ready <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_s_ready <= 1'b1;
          r_synced  <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready     = r_s_ready;
  assign FrameData   = r_frame_data;
  assign FrameStrobe = r_strobe;
  assign ColSelect   = r_colsel;
  assign synced      = r_synced;
  assign busy        = r_busy;
  assign error       = r_error;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed bench for config_frame_loader: stream-level reference model compared every cycle,
// plus hand-computed expectations at the end of each scenario.
module tb_config_frame_loader;

  localparam int          ROWS   = 16;
  localparam int          COLS   = 16;
  localparam int          FRAMES = 20;
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;

  logic                 CLK = 1'b0;
  logic                 resetn = 1'b0;
  logic [31:0]          s_data = '0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [ROWS*32-1:0]   FrameData;
  logic [FRAMES-1:0]    FrameStrobe;
  logic [COLS-1:0]      ColSelect;
  logic                 synced;
  logic                 busy;
  logic                 error;
  logic [15:0]          frame_count;

  always #5 CLK = ~CLK;

  config_frame_loader dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .ColSelect   (ColSelect),
    .synced      (synced),
    .busy        (busy),
    .error       (error),
    .frame_count (frame_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: words accepted, rows still owed for the open frame, and
  // the number of dead cycles (strobe + hold) left after a frame completes.
  logic              m_ready, m_synced, m_err, m_acc;
  logic [15:0]       m_cnt;
  int                m_need, m_post, m_col, m_frm;
  logic [31:0]       m_fd [ROWS];
  logic [FRAMES-1:0] m_fs;
  logic [COLS-1:0]   m_cs;

  always @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      m_ready = 0; m_synced = 0; m_err = 0; m_cnt = 0;
      m_need = 0; m_post = 0; m_col = 0; m_frm = 0;
      m_fs = '0; m_cs = '0;
      for (int i = 0; i < ROWS; i++) m_fd[i] = '0;
    end else begin
      m_acc = s_valid && m_ready;
      m_fs = '0;
      m_cs = '0;
      if (m_post > 0) begin
        m_post--;
      end else if (m_acc) begin
        if (!m_synced) begin
          if (s_data == SYNC) begin m_synced = 1; m_err = 0; end
        end else if (m_need > 0) begin
          m_fd[ROWS - m_need] = s_data;
          m_need--;
          if (m_need == 0) begin
            m_fs[m_frm] = 1'b1;
            m_cs[m_col] = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt++;
            m_post = 2;
          end
        end else if (s_data != SYNC) begin
          if (s_data[31:24] == 8'h01 && s_data[23:16] < COLS && s_data[15:8] < FRAMES) begin
            m_col = int'(s_data[23:16]);
            m_frm = int'(s_data[15:8]);
            m_need = ROWS;
          end else if (s_data[31:24] == 8'h02) begin
            m_synced = 0;
          end else begin
            m_synced = 0;
            m_err = 1;
          end
        end
      end
      m_ready = (m_post == 0);
    end
  end

  int                n_strobes = 0;
  logic [FRAMES-1:0] last_fs = '0;
  logic [COLS-1:0]   last_cs = '0;

  always @(negedge CLK) begin
    logic [ROWS*32-1:0] efd;
    for (int r = 0; r < ROWS; r++) efd[r*32 +: 32] = m_fd[r];
    chk("s_ready", s_ready, m_ready);
    chk("FrameStrobe", FrameStrobe, m_fs);
    chk("ColSelect", ColSelect, m_cs);
    chk("synced", synced, m_synced);
    chk("busy", busy, (m_need > 0) || (m_post > 0));
    chk("error", error, m_err);
    chk("frame_count", frame_count, m_cnt);
    chk("FrameData", FrameData, efd);
    if (FrameStrobe != '0) begin
      n_strobes++;
      last_fs = FrameStrobe;
      last_cs = ColSelect;
    end
  end

  time t_last;

  task automatic idle(input int n);
    s_valid = 0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send(input logic [31:0] w, input int gap_max);
    int   n;
    logic rdy;
    if (gap_max > 0) idle($urandom_range(gap_max, 0));
    s_valid = 1;
    s_data  = w;
    n = 0;
    do begin
      @(negedge CLK);
      rdy = s_ready;
      @(posedge CLK);
      t_last = $time;
      n++;
    end while (!rdy && n < 64);
    #1;
    chk("send_accepted", rdy, 1'b1);
  endtask

  initial begin
    logic [31:0] w;
    time         t_d;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_FrameData", FrameData, 0);
    chk("rst_strobe", FrameStrobe, 0);
    chk("rst_synced", synced, 0);
    chk("rst_count", frame_count, 0);
    resetn = 1;
    @(posedge CLK); #1;
    chk("first_ready", s_ready, 1);

    // Words before sync are discarded.
    send(32'h0103_0500, 0);
    w = $urandom;
    if (w == SYNC) w = ~w;
    send(w, 0);
    idle(3);
    chk("presync_strobes", n_strobes, 0);
    chk("presync_FrameData", FrameData, 0);
    chk("presync_synced", synced, 0);
    chk("presync_error", error, 0);

    // Basic frame: column 3, frame 5, then DESYNC.
    send(SYNC, 0);
    chk("sync_synced", synced, 1);
    send(32'h0103_0500, 0);
    for (int r = 0; r < ROWS; r++) send(32'h1000_0000 + r, 0);
    send(32'h0200_0000, 0);
    idle(2);
    chk("f1_strobes", n_strobes, 1);
    chk("f1_FrameStrobe", last_fs, 20'h00020);
    chk("f1_ColSelect", last_cs, 16'h0008);
    for (int r = 0; r < ROWS; r++) chk("f1_row", FrameData[r*32 +: 32], 32'h1000_0000 + r);
    chk("f1_count", frame_count, 1);
    chk("f1_desync", synced, 0);

    // Column 16 is out of range.
    send(SYNC, 0);
    send(32'h0110_0000, 0);
    idle(2);
    chk("badcol_error", error, 1);
    chk("badcol_synced", synced, 0);
    chk("badcol_busy", busy, 0);
    chk("badcol_strobes", n_strobes, 1);
    send(SYNC, 0);
    chk("resync_error", error, 0);
    chk("resync_synced", synced, 1);

    // Gappy valid, sync word embedded as data at row 3.
    send(32'h0107_0200, 2);
    for (int r = 0; r < ROWS; r++) send((r == 3) ? SYNC : 32'h2000_0000 + r, 2);
    idle(3);
    chk("f2_strobes", n_strobes, 2);
    chk("f2_FrameStrobe", last_fs, 20'h00004);
    chk("f2_ColSelect", last_cs, 16'h0080);
    chk("f2_row3", FrameData[3*32 +: 32], 32'hFAB0_FAB1);
    chk("f2_row4", FrameData[4*32 +: 32], 32'h2000_0004);
    chk("f2_count", frame_count, 2);

    // Reset after 8 of 16 data words.
    send(32'h0101_0100, 0);
    for (int r = 0; r < 8; r++) send(32'h4000_0000 + r, 0);
    s_valid = 0;
    resetn  = 0;
    idle(2);
    chk("midrst_FrameData", FrameData, 0);
    chk("midrst_count", frame_count, 0);
    chk("midrst_busy", busy, 0);
    resetn = 1;
    idle(4);
    chk("midrst_strobes", n_strobes, 2);
    send(SYNC, 0);
    send(32'h0101_0100, 0);
    for (int r = 0; r < ROWS; r++) send(32'h3000_0000 + r, 0);
    idle(3);
    chk("f3_strobes", n_strobes, 3);
    chk("f3_FrameStrobe", last_fs, 20'h00002);
    chk("f3_ColSelect", last_cs, 16'h0002);
    chk("f3_count", frame_count, 1);

    // Back-to-back frames with s_valid held high.
    resetn = 0;
    idle(2);
    resetn = 1;
    idle(1);
    send(SYNC, 0);
    send(32'h0102_0300, 0);
    for (int r = 0; r < ROWS; r++) send(32'h5000_0000 + r, 0);
    t_d = t_last;
    send(32'h0104_0600, 0);
    chk("b2b_gap_cycles", (t_last - t_d) / 10, 3);
    for (int r = 0; r < ROWS; r++) send(32'h6000_0000 + r, 0);
    idle(3);
    chk("b2b_strobes", n_strobes, 5);
    chk("b2b_FrameStrobe", last_fs, 20'h00040);
    chk("b2b_ColSelect", last_cs, 16'h0010);
    chk("b2b_row15", FrameData[15*32 +: 32], 32'h6000_000F);
    chk("b2b_count", frame_count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
